ram_access_arbiter: RTL and testbench

//   Front-end controller for dualPortRAM (1 write port, 2 combinational read ports).

---
 rtl/ram_access_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_access_arbiter
//  Description : Front-end for a 1W/2R RAM. Round-robin shares the write port
//                between clients A and B, gives each client a registered read
//                port with write-first forwarding, and zero-fills the RAM after
//                reset or on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_access_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  clear_req,
    output logic                  busy,

    input  logic                  wr_req_a,
    input  logic [ADDR_WIDTH-1:0] wr_addr_a,
    input  logic [DATA_WIDTH-1:0] wr_data_a,
    output logic                  wr_gnt_a,

    input  logic                  wr_req_b,
    input  logic [ADDR_WIDTH-1:0] wr_addr_b,
    input  logic [DATA_WIDTH-1:0] wr_data_b,
    output logic                  wr_gnt_b,

    input  logic                  rd_req_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic                  rd_valid_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,

    input  logic                  rd_req_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  rd_valid_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr_1,
    output logic [ADDR_WIDTH-1:0] ram_read_addr_2,
    input  logic [DATA_WIDTH-1:0] ram_read_data_1,
    input  logic [DATA_WIDTH-1:0] ram_read_data_2
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_ADDR_LAST = '1;
    localparam logic                  C_PTR_A     = 1'b0;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [ADDR_WIDTH-1:0]   w_clr_cnt_nxt;
    logic                    r_rr_ptr;
    logic                    w_rr_ptr_nxt;

    logic                    w_gnt_a;
    logic                    w_gnt_b;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic [DATA_WIDTH-1:0]   w_wdata;

    logic                    w_run;
    logic                    w_rd_en_a;
    logic                    w_rd_en_b;
    logic                    w_fwd_a;
    logic                    w_fwd_b;
    logic [DATA_WIDTH-1:0]   w_rd_next_a;
    logic [DATA_WIDTH-1:0]   w_rd_next_b;

    logic                    r_rd_valid_a;
    logic                    r_rd_valid_b;
    logic [DATA_WIDTH-1:0]   r_rd_data_a;
    logic [DATA_WIDTH-1:0]   r_rd_data_b;

    // ------------------------------------------------------------------
    // Control state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_rr_ptr  <= C_PTR_A;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, fill sequencing and write arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_gnt_a       = 1'b0;
        w_gnt_b       = 1'b0;
        w_we          = 1'b0;
        w_waddr       = '0;
        w_wdata       = '0;

        case (r_state)
            ST_CLEAR: begin
                w_we          = 1'b1;
                w_waddr       = r_clr_cnt;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == C_ADDR_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (clear_req) begin
                    // The clear request owns this cycle: no write may slip in.
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end else begin
                    if (wr_req_a && wr_req_b) begin
                        // Pointer only advances when it actually decided a contest.
                        w_gnt_a      = (r_rr_ptr == C_PTR_A);
                        w_gnt_b      = (r_rr_ptr != C_PTR_A);
                        w_rr_ptr_nxt = ~r_rr_ptr;
                    end else begin
                        w_gnt_a = wr_req_a;
                        w_gnt_b = wr_req_b;
                    end

                    if (w_gnt_a) begin
                        w_we    = 1'b1;
                        w_waddr = wr_addr_a;
                        w_wdata = wr_data_a;
                    end else if (w_gnt_b) begin
                        w_we    = 1'b1;
                        w_waddr = wr_addr_b;
                        w_wdata = wr_data_b;
                    end
                end
            end

            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read paths (write-first forwarding against this cycle's write)
    // ------------------------------------------------------------------
    assign w_run       = (r_state == ST_RUN);
    assign w_rd_en_a   = w_run && rd_req_a;
    assign w_rd_en_b   = w_run && rd_req_b;
    assign w_fwd_a     = w_we && (w_waddr == rd_addr_a);
    assign w_fwd_b     = w_we && (w_waddr == rd_addr_b);
    assign w_rd_next_a = w_fwd_a ? w_wdata : ram_read_data_1;
    assign w_rd_next_b = w_fwd_b ? w_wdata : ram_read_data_2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid_a <= 1'b0;
            r_rd_valid_b <= 1'b0;
            r_rd_data_a  <= '0;
            r_rd_data_b  <= '0;
        end else begin
            r_rd_valid_a <= w_rd_en_a;
            r_rd_valid_b <= w_rd_en_b;
            // Data holds between reads so a consumer may sample late.
            if (w_rd_en_a) begin
                r_rd_data_a <= w_rd_next_a;
            end
            if (w_rd_en_b) begin
                r_rd_data_b <= w_rd_next_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign busy            = (r_state == ST_CLEAR);
    assign wr_gnt_a        = w_gnt_a;
    assign wr_gnt_b        = w_gnt_b;

    assign ram_we          = w_we;
    assign ram_write_addr  = w_waddr;
    assign ram_write_data  = w_wdata;
    assign ram_read_addr_1 = rd_addr_a;
    assign ram_read_addr_2 = rd_addr_b;

    assign rd_valid_a      = r_rd_valid_a;
    assign rd_valid_b      = r_rd_valid_b;
    assign rd_data_a       = r_rd_data_a;
    assign rd_data_b       = r_rd_data_b;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_access_arbiter
//  Description : Self-checking bench: directed vector table, hand-written
//                clear/reset sequences and random traffic against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_req = 1'b0;
    logic          wr_req_a = 1'b0, wr_req_b = 1'b0;
    logic [AW-1:0] wr_addr_a = '0, wr_addr_b = '0;
    logic [DW-1:0] wr_data_a = '0, wr_data_b = '0;
    logic          rd_req_a = 1'b0, rd_req_b = 1'b0;
    logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0;

    logic          busy, wr_gnt_a, wr_gnt_b, rd_valid_a, rd_valid_b, ram_we;
    logic [DW-1:0] rd_data_a, rd_data_b, ram_write_data;
    logic [AW-1:0] ram_write_addr, ram_read_addr_1, ram_read_addr_2;
    logic [DW-1:0] ram_read_data_1, ram_read_data_2;

    // Stand-in for dualPortRAM, preloaded with garbage so the fill is visible.
    logic [DW-1:0] ram [DEPTH] = '{default: 8'hEE};

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) ram[ram_write_addr] <= ram_write_data;
    assign ram_read_data_1 = ram[ram_read_addr_1];
    assign ram_read_data_2 = ram[ram_read_addr_2];

    ram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
        .wr_req_a(wr_req_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a), .wr_gnt_a(wr_gnt_a),
        .wr_req_b(wr_req_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b), .wr_gnt_b(wr_gnt_b),
        .rd_req_a(rd_req_a), .rd_addr_a(rd_addr_a), .rd_valid_a(rd_valid_a), .rd_data_a(rd_data_a),
        .rd_req_b(rd_req_b), .rd_addr_b(rd_addr_b), .rd_valid_b(rd_valid_b), .rd_data_b(rd_data_b),
        .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
        .ram_read_addr_1(ram_read_addr_1), .ram_read_addr_2(ram_read_addr_2),
        .ram_read_data_1(ram_read_data_1), .ram_read_data_2(ram_read_data_2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: fill countdown, whose-turn flag, plain memory array.
    int            m_fill_left = 0;
    int            m_fill_addr = 0;
    bit            m_turn_b    = 1'b0;
    logic [DW-1:0] m_mem [DEPTH] = '{default: 8'h00};
    bit            m_va = 1'b0, m_vb = 1'b0;
    logic [DW-1:0] m_da = '0, m_db = '0;

    bit            e_busy, e_ga, e_gb, e_we;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    bit            last_ga, last_gb, s_busy, s_ga;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic predict();
        e_busy = (m_fill_left > 0);
        e_ga = 1'b0; e_gb = 1'b0; e_we = 1'b0; e_wa = '0; e_wd = '0;
        if (e_busy) begin
            e_we = 1'b1;
            e_wa = AW'(m_fill_addr);
        end else if (!clear_req) begin
            if (wr_req_a && wr_req_b) begin
                e_ga = !m_turn_b;
                e_gb = m_turn_b;
            end else begin
                e_ga = wr_req_a;
                e_gb = wr_req_b;
            end
            if (e_ga) begin e_we = 1'b1; e_wa = wr_addr_a; e_wd = wr_data_a; end
            if (e_gb) begin e_we = 1'b1; e_wa = wr_addr_b; e_wd = wr_data_b; end
        end
    endtask

    task automatic check();
        chk("busy", busy, e_busy);
        chk("wr_gnt_a", wr_gnt_a, e_ga);
        chk("wr_gnt_b", wr_gnt_b, e_gb);
        chk("ram_we", ram_we, e_we);
        if (e_we) begin
            chk("ram_write_addr", ram_write_addr, e_wa);
            chk("ram_write_data", ram_write_data, e_wd);
        end
        chk("ram_read_addr_1", ram_read_addr_1, rd_addr_a);
        chk("ram_read_addr_2", ram_read_addr_2, rd_addr_b);
        chk("rd_valid_a", rd_valid_a, m_va);
        chk("rd_valid_b", rd_valid_b, m_vb);
        chk("rd_data_a", rd_data_a, m_da);
        chk("rd_data_b", rd_data_b, m_db);
    endtask

    task automatic advance();
        if (reset) begin
            m_fill_left = DEPTH; m_fill_addr = 0; m_turn_b = 1'b0;
            m_va = 1'b0; m_vb = 1'b0; m_da = '0; m_db = '0;
        end else if (e_busy) begin
            m_va = 1'b0; m_vb = 1'b0;
            m_fill_left--; m_fill_addr++;
        end else begin
            m_va = rd_req_a;
            m_vb = rd_req_b;
            if (rd_req_a) m_da = (e_we && e_wa == rd_addr_a) ? e_wd : m_mem[rd_addr_a];
            if (rd_req_b) m_db = (e_we && e_wa == rd_addr_b) ? e_wd : m_mem[rd_addr_b];
            if (clear_req) begin
                m_fill_left = DEPTH; m_fill_addr = 0;
            end else if (wr_req_a && wr_req_b) begin
                m_turn_b = !m_turn_b;
            end
        end
        if (e_we) m_mem[e_wa] = e_wd;
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic tick();
        #1;
        predict();
        s_busy = busy;
        s_ga   = wr_gnt_a;
        if (!reset) check();
        advance();
        last_ga = e_ga;
        last_gb = e_gb;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0; wr_req_a = 1'b0; wr_req_b = 1'b0;
        rd_req_a = 1'b0; rd_req_b = 1'b0;
    endtask

    task automatic count_busy(input string nm);
        int cnt = 0;
        int guard = 0;
        do begin
            tick();
            if (s_busy) cnt++;
            guard++;
        end while (s_busy && guard < 40);
        chk(nm, cnt, DEPTH);
    endtask

    typedef struct {
        bit wa; logic [AW-1:0] aa; logic [DW-1:0] da;
        bit wb; logic [AW-1:0] ab; logic [DW-1:0] db;
        bit ra; logic [AW-1:0] raa; bit rb; logic [AW-1:0] rab;
        bit ga; bit gb; bit va; logic [DW-1:0] xa; bit vb; logic [DW-1:0] xb;
    } vec_t;

    vec_t tbl [14];

    initial begin
        //          wa aa  da     wb ab  db     ra raa rb rab  ga gb va xa     vb xb
        tbl[0]  = '{1, 3, 8'h5A, 0, 0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 8'h00, 0, 8'h00};
        tbl[1]  = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 3, 0, 0,  0, 0, 0, 8'h00, 0, 8'h00};
        tbl[2]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 8'h5A, 0, 8'h00};
        tbl[3]  = '{1, 5, 8'h11, 1, 6, 8'h22, 0, 0, 0, 0,  1, 0, 0, 8'h5A, 0, 8'h00};
        tbl[4]  = '{1, 5, 8'h33, 1, 6, 8'h22, 0, 0, 0, 0,  0, 1, 0, 8'h5A, 0, 8'h00};
        tbl[5]  = '{1, 5, 8'h33, 1, 6, 8'h44, 0, 0, 0, 0,  1, 0, 0, 8'h5A, 0, 8'h00};
        tbl[6]  = '{1, 5, 8'h33, 1, 6, 8'h44, 0, 0, 0, 0,  0, 1, 0, 8'h5A, 0, 8'h00};
        tbl[7]  = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 5, 1, 6,  0, 0, 0, 8'h5A, 0, 8'h00};
        tbl[8]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 8'h33, 1, 8'h44};
        tbl[9]  = '{0, 0, 8'h00, 1, 9, 8'h77, 1, 9, 0, 0,  0, 1, 0, 8'h33, 0, 8'h44};
        tbl[10] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 9,  0, 0, 1, 8'h77, 0, 8'h44};
        tbl[11] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 8'h77, 1, 8'h77};
        tbl[12] = '{1, 1, 8'h01, 1, 2, 8'h02, 0, 0, 0, 0,  1, 0, 0, 8'h77, 0, 8'h77};
        tbl[13] = '{0, 0, 8'h00, 1, 2, 8'h02, 0, 0, 0, 0,  0, 1, 0, 8'h77, 0, 8'h77};

        @(negedge clk);
        // Power-up reset, then the full zero-fill.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("busy_after_reset", busy, 1);
        count_busy("fill_len_after_reset");

        // Every address reads back zero on both ports.
        for (int a = 0; a < DEPTH; a++) begin
            rd_req_a = 1'b1; rd_addr_a = AW'(a);
            rd_req_b = 1'b1; rd_addr_b = AW'(DEPTH - 1 - a);
            tick();
        end
        idle_inputs();
        tick();

        // Directed vectors: single write, contention, forwarding, pointer hold.
        for (int i = 0; i < 14; i++) begin
            wr_req_a = tbl[i].wa; wr_addr_a = tbl[i].aa; wr_data_a = tbl[i].da;
            wr_req_b = tbl[i].wb; wr_addr_b = tbl[i].ab; wr_data_b = tbl[i].db;
            rd_req_a = tbl[i].ra; rd_addr_a = tbl[i].raa;
            rd_req_b = tbl[i].rb; rd_addr_b = tbl[i].rab;
            clear_req = 1'b0;
            #1;
            chk($sformatf("tbl%0d wr_gnt_a", i), wr_gnt_a, tbl[i].ga);
            chk($sformatf("tbl%0d wr_gnt_b", i), wr_gnt_b, tbl[i].gb);
            chk($sformatf("tbl%0d rd_valid_a", i), rd_valid_a, tbl[i].va);
            chk($sformatf("tbl%0d rd_data_a", i), rd_data_a, tbl[i].xa);
            chk($sformatf("tbl%0d rd_valid_b", i), rd_valid_b, tbl[i].vb);
            chk($sformatf("tbl%0d rd_data_b", i), rd_data_b, tbl[i].xb);
            tick();
        end
        idle_inputs();
        tick();

        // clear_req while A is writing: no grant, refill, then A goes through.
        wr_req_a = 1'b1; wr_addr_a = 4'd4; wr_data_a = 8'hAB; clear_req = 1'b1;
        #1;
        chk("clear_cycle wr_gnt_a", wr_gnt_a, 0);
        chk("clear_cycle ram_we", ram_we, 0);
        tick();
        clear_req = 1'b0;
        rd_req_a = 1'b1; rd_addr_a = 4'd4;
        rd_req_b = 1'b1; rd_addr_b = 4'd5;
        count_busy("fill_len_after_clear");
        chk("gnt_a_after_clear", s_ga, 1);
        idle_inputs();
        tick();
        tick();

        // Reset in the middle of a fill restarts from address 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("restart_addr", ram_write_addr, 0);
        count_busy("fill_len_after_midfill_reset");

        // Random traffic; writers hold their request until granted.
        begin
            bit pa = 1'b0, pb = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (!pa && $urandom_range(0, 2) != 0) begin
                    pa = 1'b1; wr_addr_a = AW'($urandom); wr_data_a = DW'($urandom);
                end
                if (!pb && $urandom_range(0, 2) != 0) begin
                    pb = 1'b1; wr_addr_b = AW'($urandom); wr_data_b = DW'($urandom);
                end
                wr_req_a  = pa;
                wr_req_b  = pb;
                rd_req_a  = $urandom_range(0, 1) == 1;
                rd_addr_a = AW'($urandom);
                rd_req_b  = $urandom_range(0, 1) == 1;
                rd_addr_b = AW'($urandom);
                clear_req = ($urandom_range(0, 79) == 0);
                tick();
                if (last_ga) pa = 1'b0;
                if (last_gb) pb = 1'b0;
            end
        end
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
